// File: rtl/vending_bank.sv
`default_nettype none
// ============================================================================
// Module   : vending_bank
// Purpose  : Multi-machine vending controller with per-machine pricing mode,
//            saturating stock counters and an optional REFILL_EN restock path.
// Revision : 1.0 - initial release
// ============================================================================
module vending_bank #(
   parameter int                      NUM_VM          = 2,
   parameter int                      NUM_PRODUCTS    = 5,
   parameter int                      PID_W           = 3,
   parameter int                      MONEY_W         = 6,
   parameter int                      STOCK_W         = 5,
   parameter int                      INIT_STOCK      = 10,
   parameter int                      PRICE_BASE      = 10,
   parameter int                      PRICE_STEP      = 5,
   parameter logic [NUM_VM-1:0]       EXACT_MASK      = 2'b01,
   parameter logic [NUM_PRODUCTS-1:0] SUGAR_MASK      = 5'b11100,
   parameter int                      DISPENSE_CYCLES = 3,
   parameter int                      VM_W            = $clog2(NUM_VM)
) (
   input  logic               CLK,
   input  logic               RSTN,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [VM_W-1:0]    vm,
   input  logic [PID_W-1:0]   productID,
   input  logic [MONEY_W-1:0] money,
   input  logic               sugar,
   input  logic               restock_valid,
   input  logic [VM_W-1:0]    restock_vm,
   input  logic [PID_W-1:0]   restock_pid,
   input  logic [STOCK_W-1:0] restock_qty,
   output logic               resp_valid,
   output logic [MONEY_W-1:0] moneyLeft,
   output logic [STOCK_W-1:0] itemLeft,
   output logic               productUnavailable,
   output logic               insufficientFund,
   output logic               notExactFund,
   output logic               invalidProduct,
   output logic               sugarUnsuitable,
   output logic               productReady
);

   localparam int CNT_W = $clog2(DISPENSE_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_CHECK    = 2'd1,
      S_DISPENSE = 2'd2,
      S_RESP     = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [VM_W-1:0]      vm_q, vm_d;
   logic [PID_W-1:0]     pid_q, pid_d;
   logic [MONEY_W-1:0]   money_q, money_d;
   logic                 sugar_q, sugar_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   // Result is computed in CHECK but only becomes visible on entry to RESP.
   logic [5:0]           pend_flags_q, pend_flags_d;
   logic [MONEY_W-1:0]   pend_money_q, pend_money_d;
   logic [STOCK_W-1:0]   pend_item_q, pend_item_d;
   logic [5:0]           flags_q, flags_d;
   logic [MONEY_W-1:0]   money_left_q, money_left_d;
   logic [STOCK_W-1:0]   item_left_q, item_left_d;

   logic [STOCK_W-1:0]   stock_q [NUM_VM][NUM_PRODUCTS];
   logic [STOCK_W-1:0]   stock_d [NUM_VM][NUM_PRODUCTS];

   logic                 chk_ok;
   logic [5:0]           chk_flags;
   logic [MONEY_W-1:0]   chk_money;
   logic [STOCK_W-1:0]   chk_item;
   logic                 pid_valid;
   logic [MONEY_W-1:0]   price;
   logic [STOCK_W-1:0]   cur_stock;
   logic                 disp_fire;

   // Flag order: [0] invalid, [1] unavailable, [2] insufficient,
   // [3] not exact, [4] sugar unsuitable, [5] product ready.
   always_comb begin
      pid_valid = 32'(pid_q) < NUM_PRODUCTS;
      price     = MONEY_W'(PRICE_BASE + PRICE_STEP * 32'(pid_q));
      cur_stock = pid_valid ? stock_q[vm_q][pid_q] : '0;
      chk_ok    = 1'b0;
      chk_flags = '0;
      chk_money = money_q;
      chk_item  = cur_stock;
      if (!pid_valid) begin
         chk_flags[0] = 1'b1;
      end else if (cur_stock == '0) begin
         chk_flags[1] = 1'b1;
      end else if (money_q < price) begin
         chk_flags[2] = 1'b1;
      end else if (EXACT_MASK[vm_q] && (money_q != price)) begin
         chk_flags[3] = 1'b1;
      end else if (sugar_q && !SUGAR_MASK[pid_q]) begin
         chk_flags[4] = 1'b1;
      end else begin
         chk_flags[5] = 1'b1;
         chk_ok       = 1'b1;
         chk_money    = money_q - price;
         chk_item     = cur_stock - 1'b1;
      end
   end

   assign disp_fire = (state_q == S_CHECK) && chk_ok;

   for (genvar v = 0; v < NUM_VM; v++) begin : g_vm
      for (genvar p = 0; p < NUM_PRODUCTS; p++) begin : g_pid
         logic               dec;
         logic [STOCK_W-1:0] qty;
         logic [STOCK_W:0]   sum;
         assign dec = disp_fire && (vm_q == VM_W'(v)) && (pid_q == PID_W'(p));
`ifdef REFILL_EN
         assign qty = (restock_valid && (restock_vm == VM_W'(v)) &&
                       (restock_pid == PID_W'(p))) ? restock_qty : '0;
`else
         assign qty = '0;
`endif
         // dec only fires on a non-empty counter, so the sum never underflows.
         assign sum = {1'b0, stock_q[v][p]} + {1'b0, qty} - {{STOCK_W{1'b0}}, dec};
         assign stock_d[v][p] = sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
      end
   end

`ifndef REFILL_EN
   logic unused_restock;
   assign unused_restock = ^{restock_valid, restock_vm, restock_pid, restock_qty};
`endif

   always_comb begin
      state_d      = state_q;
      vm_d         = vm_q;
      pid_d        = pid_q;
      money_d      = money_q;
      sugar_d      = sugar_q;
      cnt_d        = cnt_q;
      pend_flags_d = pend_flags_q;
      pend_money_d = pend_money_q;
      pend_item_d  = pend_item_q;
      flags_d      = flags_q;
      money_left_d = money_left_q;
      item_left_d  = item_left_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               vm_d    = vm;
               pid_d   = productID;
               money_d = money;
               sugar_d = sugar;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            pend_flags_d = chk_flags;
            pend_money_d = chk_money;
            pend_item_d  = chk_item;
            if (chk_ok) begin
               cnt_d   = CNT_W'(DISPENSE_CYCLES - 1);
               state_d = S_DISPENSE;
            end else begin
               state_d = S_RESP;
            end
         end
         S_DISPENSE: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // RESP always exits after one cycle, so this only fires on entry.
      if (state_d == S_RESP) begin
         flags_d      = pend_flags_d;
         money_left_d = pend_money_d;
         item_left_d  = pend_item_d;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q      <= S_IDLE;
         vm_q         <= '0;
         pid_q        <= '0;
         money_q      <= '0;
         sugar_q      <= 1'b0;
         cnt_q        <= '0;
         pend_flags_q <= '0;
         pend_money_q <= '0;
         pend_item_q  <= '0;
         flags_q      <= '0;
         money_left_q <= '0;
         item_left_q  <= '0;
         for (int v = 0; v < NUM_VM; v++) begin
            for (int p = 0; p < NUM_PRODUCTS; p++) begin
               stock_q[v][p] <= STOCK_W'(INIT_STOCK);
            end
         end
      end else begin
         state_q      <= state_d;
         vm_q         <= vm_d;
         pid_q        <= pid_d;
         money_q      <= money_d;
         sugar_q      <= sugar_d;
         cnt_q        <= cnt_d;
         pend_flags_q <= pend_flags_d;
         pend_money_q <= pend_money_d;
         pend_item_q  <= pend_item_d;
         flags_q      <= flags_d;
         money_left_q <= money_left_d;
         item_left_q  <= item_left_d;
         stock_q      <= stock_d;
      end
   end

   assign req_ready          = (state_q == S_IDLE);
   assign resp_valid         = (state_q == S_RESP);
   assign moneyLeft          = money_left_q;
   assign itemLeft           = item_left_q;
   assign invalidProduct     = flags_q[0];
   assign productUnavailable = flags_q[1];
   assign insufficientFund   = flags_q[2];
   assign notExactFund       = flags_q[3];
   assign sugarUnsuitable    = flags_q[4];
   assign productReady       = flags_q[5];

endmodule
`default_nettype wire

// File: tb/tb_vending_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_vending_bank
// Purpose  : Scoreboard bench for vending_bank; restock checks need REFILL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vending_bank;

   localparam int          NUM_VM          = 2;
   localparam int          NUM_PRODUCTS    = 5;
   localparam int          PID_W           = 3;
   localparam int          MONEY_W         = 6;
   localparam int          STOCK_W         = 5;
   localparam int          VM_W            = 1;
   localparam int          PRICE_BASE      = 10;
   localparam int          PRICE_STEP      = 5;
   localparam int          DISPENSE_CYCLES = 3;
   localparam int          STOCK_MAX       = 31;
   localparam logic [1:0]  EXACT           = 2'b01;
   localparam logic [4:0]  SUGAR_OK        = 5'b11100;

   logic               CLK = 1'b0;
   logic               RSTN = 1'b0;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic [VM_W-1:0]    vm_s = '0;
   logic [PID_W-1:0]   pid_s = '0;
   logic [MONEY_W-1:0] money_s = '0;
   logic               sugar_s = 1'b0;
   logic               restock_valid = 1'b0;
   logic [VM_W-1:0]    restock_vm = '0;
   logic [PID_W-1:0]   restock_pid = '0;
   logic [STOCK_W-1:0] restock_qty = '0;
   logic               resp_valid;
   logic [MONEY_W-1:0] moneyLeft;
   logic [STOCK_W-1:0] itemLeft;
   logic               productUnavailable, insufficientFund, notExactFund;
   logic               invalidProduct, sugarUnsuitable, productReady;

   vending_bank dut (
      .CLK(CLK), .RSTN(RSTN),
      .req_valid(req_valid), .req_ready(req_ready),
      .vm(vm_s), .productID(pid_s), .money(money_s), .sugar(sugar_s),
      .restock_valid(restock_valid), .restock_vm(restock_vm),
      .restock_pid(restock_pid), .restock_qty(restock_qty),
      .resp_valid(resp_valid), .moneyLeft(moneyLeft), .itemLeft(itemLeft),
      .productUnavailable(productUnavailable), .insufficientFund(insufficientFund),
      .notExactFund(notExactFund), .invalidProduct(invalidProduct),
      .sugarUnsuitable(sugarUnsuitable), .productReady(productReady)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [5:0] flags;
      int         money;
      int         item;
      int         lat;
      int         acc;
      bit         chk_item;
   } exp_t;

   exp_t q[$];
   int   stock [NUM_VM][NUM_PRODUCTS];
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Flag order: [0] invalid [1] unavailable [2] insufficient [3] not exact
   // [4] sugar unsuitable [5] ready.
   task automatic model_req(input int vm, input int pid, input int money,
                            input bit sugar, output exp_t e);
      int price;
      price      = PRICE_BASE + PRICE_STEP * pid;
      e.flags    = '0;
      e.money    = money;
      e.item     = 0;
      e.lat      = 1;
      e.acc      = 0;
      e.chk_item = 1'b1;
      if (pid >= NUM_PRODUCTS) begin
         e.flags[0] = 1'b1;
      end else begin
         e.item = stock[vm][pid];
         if (stock[vm][pid] == 0)                   e.flags[1] = 1'b1;
         else if (money < price)                    e.flags[2] = 1'b1;
         else if (EXACT[vm] && money != price)      e.flags[3] = 1'b1;
         else if (sugar && !SUGAR_OK[pid])          e.flags[4] = 1'b1;
         else begin
            e.flags[5] = 1'b1;
            e.money    = money - price;
            stock[vm][pid] = stock[vm][pid] - 1;
            e.item     = stock[vm][pid];
            e.lat      = 1 + DISPENSE_CYCLES;
         end
      end
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (RSTN && resp_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_resp", 1, 0);
         end else begin
            e = q.pop_front();
            chk("flags", int'({productReady, sugarUnsuitable, notExactFund,
                               insufficientFund, productUnavailable, invalidProduct}),
                int'(e.flags));
            chk("moneyLeft", int'(moneyLeft), e.money);
            if (e.chk_item) chk("itemLeft", int'(itemLeft), e.item);
            chk("latency", cyc - e.acc, e.lat);
         end
      end
   end

   task automatic do_req(input int vm, input int pid, input int money,
                         input bit sugar, input bit coincide);
      exp_t e;
      bit   got;
      @(negedge CLK);
      vm_s = VM_W'(vm); pid_s = PID_W'(pid); money_s = MONEY_W'(money); sugar_s = sugar;
      req_valid = 1'b1;
      for (int t = 0; t < 50 && !req_ready; t++) @(negedge CLK);
      if (!req_ready) begin
         chk("ready_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      model_req(vm, pid, money, sugar, e);
      e.acc = cyc + 1;
      if (coincide) begin
         e.chk_item = 1'b0;
         if (e.flags[5] && stock[vm][pid] < STOCK_MAX) stock[vm][pid] = stock[vm][pid] + 1;
      end
      q.push_back(e);
      got = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge CLK);
         if (resp_valid) begin
            got = 1'b1;
            break;
         end
         // Busy-time noise: must be ignored while not ready.
         vm_s = VM_W'($urandom_range(0, 1));
         pid_s = PID_W'($urandom_range(0, 7));
         money_s = MONEY_W'($urandom_range(0, 63));
         sugar_s = 1'($urandom_range(0, 1));
         req_valid = 1'($urandom_range(0, 1));
         if (coincide && t == 0) begin
            restock_valid = 1'b1; restock_vm = VM_W'(vm);
            restock_pid = PID_W'(pid); restock_qty = STOCK_W'(1);
         end else begin
            restock_valid = 1'b0;
         end
      end
      if (!got) chk("resp_timeout", 0, 1);
      @(negedge CLK);
      req_valid = 1'b0;
      restock_valid = 1'b0;
      chk("ready_after_resp", int'(req_ready), 1);
   endtask

   task automatic do_restock(input int vm, input int pid, input int qty);
      @(negedge CLK);
      restock_valid = 1'b1; restock_vm = VM_W'(vm);
      restock_pid = PID_W'(pid); restock_qty = STOCK_W'(qty);
      @(negedge CLK);
      restock_valid = 1'b0;
      if (pid < NUM_PRODUCTS)
         stock[vm][pid] = (stock[vm][pid] + qty > STOCK_MAX) ? STOCK_MAX : stock[vm][pid] + qty;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_ready"}, int'(req_ready), 1);
      chk({tag, "_resp_valid"}, int'(resp_valid), 0);
      chk({tag, "_flags"}, int'({productReady, sugarUnsuitable, notExactFund,
                                 insufficientFund, productUnavailable, invalidProduct}), 0);
      chk({tag, "_moneyLeft"}, int'(moneyLeft), 0);
      chk({tag, "_itemLeft"}, int'(itemLeft), 0);
   endtask

   initial begin
      for (int v = 0; v < NUM_VM; v++)
         for (int p = 0; p < NUM_PRODUCTS; p++) stock[v][p] = 10;
      repeat (2) @(negedge CLK);
      check_idle_outputs("reset");
      RSTN = 1'b1;

      do_req(1, 2, 30, 1'b1, 1'b0);   // change-giving success
      do_req(0, 1, 20, 1'b0, 1'b0);   // not exact
      do_req(0, 0, 10, 1'b1, 1'b0);   // sugar unsuitable
      do_req(0, 6, 63, 1'b0, 1'b0);   // invalid product
      for (int i = 0; i < 10; i++) do_req(1, 0, 10, 1'b0, 1'b0);
      do_req(1, 0, 5, 1'b0, 1'b0);    // unavailable beats insufficient
      do_req(0, 0, 10, 1'b0, 1'b0);   // independent stock

`ifdef REFILL_EN
      do_restock(1, 0, 25);
      do_req(1, 0, 10, 1'b0, 1'b0);
      do_restock(1, 0, 25);
      do_req(1, 0, 10, 1'b0, 1'b0);
      do_req(1, 0, 10, 1'b0, 1'b1);   // restock on the decrement edge
      do_req(1, 0, 10, 1'b0, 1'b0);
      do_restock(1, 6, 5);            // invalid pid ignored
      do_req(1, 3, 25, 1'b0, 1'b0);
`endif

      for (int i = 0; i < 60; i++)
         do_req(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'b0);

      // Abort a request in DISPENSE with an asynchronous reset.
      @(negedge CLK);
      vm_s = 1'b1; pid_s = 3'd1; money_s = 6'd40; sugar_s = 1'b0;
      req_valid = 1'b1;
      chk("abort_ready", int'(req_ready), 1);
      @(negedge CLK);
      req_valid = 1'b0;
      @(negedge CLK);
      #2 RSTN = 1'b0;
      #1 check_idle_outputs("midreset");
      for (int v = 0; v < NUM_VM; v++)
         for (int p = 0; p < NUM_PRODUCTS; p++) stock[v][p] = 10;
      @(negedge CLK);
      RSTN = 1'b1;
      for (int t = 0; t < 8; t++) begin
         @(negedge CLK);
         chk("no_resp_after_reset", int'(resp_valid), 0);
      end
      do_req(1, 1, 40, 1'b0, 1'b0);
      do_req(1, 0, 10, 1'b0, 1'b0);

      for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge CLK);
      chk("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vending_bank.md
# vending_bank

Parametrised multi-machine vending controller, successor to the single-request lab vending logic. One shared request port serves NUM_VM independent machines. Each machine holds NUM_PRODUCTS stock counters and has a per-machine pricing mode (exact-fund or change-giving). Requests follow a valid/ready handshake, dispense is multi-cycle, and each request yields a one-cycle response pulse with a single status flag.

## Interface
- NUM_VM, 2: machine count, power of two ≥2; VM_W = $clog2(NUM_VM)
- NUM_PRODUCTS, 5: valid product IDs 0..NUM_PRODUCTS-1
- PID_W, 3: productID width; IDs ≥ NUM_PRODUCTS are invalid
- MONEY_W, 6: money width
- STOCK_W, 5: stock counter width, saturating
- INIT_STOCK, 10: reset value of every stock counter
- PRICE_BASE, 10; PRICE_STEP, 5: price(p) = PRICE_BASE + PRICE_STEP*p, MONEY_W bits, must not overflow
- EXACT_MASK, 2'b01: bit v=1 means machine v requires exact money
- SUGAR_MASK, 5'b11100: bit p=1 means product p accepts sugar
- DISPENSE_CYCLES, 3: cycles spent in DISPENSE, ≥1
- CLK  in  1  clock, rising edge
- RSTN  in  1  asynchronous, active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  high only in IDLE
- vm  in  VM_W  target machine
- productID  in  PID_W  product
- money  in  MONEY_W  inserted money
- sugar  in  1  sugar requested
- restock_valid  in  1  restock strobe (REFILL_EN only)
- restock_vm  in  VM_W; restock_pid  in  PID_W; restock_qty  in  STOCK_W
- resp_valid  out  1  one-cycle response pulse
- moneyLeft  out  MONEY_W; itemLeft  out  STOCK_W
- productUnavailable, insufficientFund, notExactFund, invalidProduct, sugarUnsuitable, productReady  out  1 each

## Operation
- FSM: IDLE → CHECK → (DISPENSE →) RESP → IDLE.
- IDLE: req_ready=1. Inputs are captured into registers at the edge where req_valid && req_ready.
- CHECK: evaluates the captured request. Exactly one flag is chosen, by priority:
  - invalidProduct: pid ≥ NUM_PRODUCTS
  - productUnavailable: stock == 0
  - insufficientFund: money < price
  - notExactFund: EXACT_MASK[vm] and money != price
  - sugarUnsuitable: sugar && !SUGAR_MASK[pid]
  - otherwise success
- Failure: CHECK → RESP.
  - moneyLeft = money (full refund).
  - itemLeft = current stock, or 0 when invalidProduct.
- Success: CHECK → DISPENSE.
  - stock[vm][pid] decrements on that edge.
  - Remains in DISPENSE for DISPENSE_CYCLES cycles, then → RESP.
  - productReady=1, moneyLeft = money − price, itemLeft = stock after decrement.
- RESP: resp_valid=1 for one cycle, then → IDLE.
- Flags, moneyLeft and itemLeft are registered and updated only on entry to RESP. They hold their values until the next RESP.
- Stock counters of other machines and other products are never affected by a request.

## Timing
- Reset, asynchronous: state=IDLE, req_ready=1, resp_valid=0, all flags 0, moneyLeft=0, itemLeft=0, every stock counter = INIT_STOCK.
- Failure latency: resp_valid is high in the cycle after the 2nd rising edge following acceptance.
- Success latency: resp_valid is high after 2+DISPENSE_CYCLES edges.
- req_ready is low from acceptance until the edge that leaves RESP.
- req_valid while not ready is ignored; it is not queued.
- Input changes after acceptance do not affect the request in flight.
- Reset mid-operation aborts the request: no resp_valid, and stock returns to INIT_STOCK.

## Configuration
- REFILL_EN defined:
  - restock_valid is sampled every cycle, in any state.
  - stock[restock_vm][restock_pid] += restock_qty, saturating at 2^STOCK_W−1.
  - Invalid restock_pid is ignored.
  - If restock coincides with a dispense decrement on the same counter, result = sat(stock − 1 + qty).
- REFILL_EN undefined: restock ports remain present but are ignored, and stock only decreases.

## Test plan
- Change-giving success, defaults: vm=1 pid=2 money=30 sugar=1 → resp_valid 5 edges after accept, productReady=1, moneyLeft=10, itemLeft=9.
- Exact-fund failure: vm=0 pid=1 money=20 → notExactFund=1 only, moneyLeft=20, itemLeft=10, resp 2 edges after accept, req_ready high the cycle after. Then vm=0 pid=0 money=10 sugar=1 → sugarUnsuitable=1.
- Invalid product: pid=6 money=63 → invalidProduct=1, itemLeft=0, moneyLeft=63.
- Drain: 10× vm=1 pid=0 money=10 → itemLeft 9..0. Then money=5 → productUnavailable=1 (priority over insufficientFund). Then vm=0 pid=0 → itemLeft=9 (independent stock).
- REFILL_EN: on a drained vm=1 pid=0, restock qty=25 → stock 25; qty=25 again → 31 (saturated). Restock qty=1 on the same edge as a dispense decrement → stock unchanged.
- Reset mid-DISPENSE: drop RSTN → req_ready=1, resp_valid=0, all outputs 0, stock 10; no response after release.
